nonce_sequencer_ctrl: RTL and testbench

//  Controls the nonce search around the input concatenator and the hash core.
//  - Drives the concatenator's selector and its 8x4-bit nonce array.
//  - Pulses hash_start once the concatenated block is registered.
//  - Waits for the hash result and compares it against a target.
//  - Steps the nonce until it finds a hit, runs out of nonces, or times out.

---
 rtl/nonce_sequencer_ctrl.sv | 81 ++++++++
 tb/tb_nonce_sequencer_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sequencer_ctrl.sv
// nonce_sequencer_ctrl: steps a 32-bit nonce through load/issue/wait rounds with the hash core
// until a hash falls below the latched target, the nonce range runs out, or the core times out.
module nonce_sequencer_ctrl #(
  parameter int          HASH_W    = 24,
  parameter logic [31:0] MAX_NONCE = 32'hFFFFFFFF,
  parameter int          TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [HASH_W-1:0] target,
  input  logic              hash_valid,
  input  logic [HASH_W-1:0] hash_in,
  output logic              selector,
  output logic [7:0][3:0]   nonce,
  output logic              hash_start,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic              timeout_err,
  output logic [31:0]       nonce_found,
  output logic [31:0]       attempts
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FOUND, EXHAUSTED, ERROR} state_t;
  state_t state, state_nx;
  logic [31:0] nonce_cnt;
  logic [HASH_W-1:0] target_q;
  logic [7:0] timer;
  logic go, hit, last, tmo;
  assign go = start && !busy;
  assign hit = hash_in < target_q;
  assign last = nonce_cnt == MAX_NONCE;
  assign tmo = timer + 8'd1 == 8'(TIMEOUT);
  assign nonce = nonce_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FOUND, EXHAUSTED, ERROR: state_nx = start ? LOAD : state;
      LOAD:    state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = hash_valid ? (hit ? FOUND : last ? EXHAUSTED : LOAD) : tmo ? ERROR : WAIT;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_comb begin
    busy        = state inside {LOAD, ISSUE, WAIT};
    selector    = busy;
    hash_start  = state == ISSUE;
    found       = state == FOUND;
    exhausted   = state == EXHAUSTED;
    timeout_err = state == ERROR;
  end
  // abort freezes the datapath so a coincident start or hash result leaves no trace
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      nonce_cnt   <= '0;
      nonce_found <= '0;
      attempts    <= '0;
      target_q    <= '0;
      timer       <= '0;
    end else if (!abort) begin
      if (go) begin
        nonce_cnt <= '0;
        attempts  <= '0;
        target_q  <= target;
      end
      if (state == ISSUE) timer <= '0;
      if (state == WAIT) begin
        if (hash_valid) begin
          attempts <= attempts + {31'd0, ~&attempts};
          if (hit) nonce_found <= nonce_cnt;
          else if (!last) nonce_cnt <= nonce_cnt + 32'd1;
        end else timer <= timer + 8'd1;
      end
    end
endmodule

// File: tb/tb_nonce_sequencer_ctrl.sv
// tb_nonce_sequencer_ctrl: randomized bench; expected outcomes come from the search rules
// (first nonce whose hash is below target, attempts, 3+latency cycles per round).
module tb_nonce_sequencer_ctrl;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic start_a = 0, start_b = 0, abort = 0, spur = 0;
  logic [23:0] target = 0;
  logic rv_a = 0, rv_b = 0;
  logic [23:0] rh_a = 0, rh_b = 0;
  logic hash_valid_a, hash_valid_b;
  logic [23:0] hash_in_a;
  logic selector_a, hash_start_a, busy_a, found_a, exhausted_a, timeout_err_a;
  logic selector_b, hash_start_b, busy_b, found_b, exhausted_b, timeout_err_b;
  logic [7:0][3:0] nonce_a, nonce_b;
  logic [31:0] nonce_found_a, attempts_a, nonce_found_b, attempts_b;
  logic [23:0] hv [16];
  int lat = 0, cnt_a = -1, cnt_b = -1;
  bit mute = 0;
  int errors = 0, checks = 0;
  logic [31:0] last_nf_a = 0, last_nf_b = 0;
  assign hash_valid_a = rv_a | spur;
  assign hash_in_a = spur ? 24'd0 : rh_a;
  assign hash_valid_b = rv_b;

  nonce_sequencer_ctrl #(.HASH_W(24), .TIMEOUT(8)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort), .target(target),
    .hash_valid(hash_valid_a), .hash_in(hash_in_a), .selector(selector_a), .nonce(nonce_a),
    .hash_start(hash_start_a), .busy(busy_a), .found(found_a), .exhausted(exhausted_a),
    .timeout_err(timeout_err_a), .nonce_found(nonce_found_a), .attempts(attempts_a));

  nonce_sequencer_ctrl #(.HASH_W(24), .MAX_NONCE(32'd3), .TIMEOUT(8)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort), .target(target),
    .hash_valid(hash_valid_b), .hash_in(rh_b), .selector(selector_b), .nonce(nonce_b),
    .hash_start(hash_start_b), .busy(busy_b), .found(found_b), .exhausted(exhausted_b),
    .timeout_err(timeout_err_b), .nonce_found(nonce_found_b), .attempts(attempts_b));

  // hash core models: answer lat cycles after the first WAIT cycle with hv[nonce]
  always @(negedge clk) begin
    rv_a = 0;
    if (hash_start_a) cnt_a = mute ? -1 : lat;
    else if (cnt_a > 0) cnt_a--;
    else if (cnt_a == 0) begin rv_a = 1; rh_a = hv[nonce_a[0]]; cnt_a = -1; end
  end
  always @(negedge clk) begin
    rv_b = 0;
    if (hash_start_b) cnt_b = lat;
    else if (cnt_b > 0) cnt_b--;
    else if (cnt_b == 0) begin rv_b = 1; rh_b = hv[nonce_b[0]]; cnt_b = -1; end
  end

  task automatic go_a(); start_a = 1; @(negedge clk); start_a = 0; endtask
  task automatic go_b(); start_b = 1; @(negedge clk); start_b = 0; endtask
  task automatic wait_a(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk); cyc++;
      if (found_a || exhausted_a || timeout_err_a) break;
    end
  endtask
  task automatic wait_b(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk); cyc++;
      if (found_b || exhausted_b || timeout_err_b) break;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({selector_a, busy_a, hash_start_a, found_a, exhausted_a, timeout_err_a} !== 6'b0) begin
      errors++; $display("FAIL reset_flags_a got=%b exp=000000", {selector_a, busy_a, hash_start_a, found_a, exhausted_a, timeout_err_a});
    end
    checks++;
    if ({nonce_a, nonce_found_a, attempts_a} !== 96'b0) begin
      errors++; $display("FAIL reset_regs_a got=%h exp=0", {nonce_a, nonce_found_a, attempts_a});
    end
    checks++;
    if ({selector_b, busy_b, hash_start_b, found_b, exhausted_b, timeout_err_b, nonce_b, nonce_found_b, attempts_b} !== 102'b0) begin
      errors++; $display("FAIL reset_all_b got=%h exp=0", {selector_b, busy_b, nonce_b, nonce_found_b, attempts_b});
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_found();
    int cyc;
    for (int i = 0; i < 16; i++) hv[i] = (i == 5) ? 24'h0000FF : 24'hFFFFFF;
    target = 24'h000100; lat = $urandom_range(0, 3); mute = 0;
    go_a(); wait_a(cyc);
    checks++; if (found_a !== 1'b1) begin errors++; $display("FAIL found_flag got=%b exp=1", found_a); end
    checks++; if (nonce_found_a !== 32'd5) begin errors++; $display("FAIL found_nonce got=%0d exp=5", nonce_found_a); end
    checks++; if (attempts_a !== 32'd6) begin errors++; $display("FAIL found_attempts got=%0d exp=6", attempts_a); end
    checks++; if (cyc !== 6 * (3 + lat)) begin errors++; $display("FAIL found_cycles got=%0d exp=%0d", cyc, 6 * (3 + lat)); end
    repeat (3) @(negedge clk);
    checks++;
    if ({found_a, busy_a, selector_a, nonce_a} !== {3'b100, 32'd5}) begin
      errors++; $display("FAIL found_hold got=%b/%h exp=100/00000005", {found_a, busy_a, selector_a}, nonce_a);
    end
    last_nf_a = 5;
  endtask

  task automatic test_exhaust();
    int cyc, np;
    for (int i = 0; i < 16; i++) hv[i] = 24'hFFFFFF;
    target = 24'h000100; lat = $urandom_range(0, 3);
    go_b();
    cyc = 0; np = 0;
    while (cyc < 500 && !exhausted_b && !found_b && !timeout_err_b) begin
      @(negedge clk); cyc++;
      if (hash_start_b) np++;
    end
    checks++; if (np !== 4) begin errors++; $display("FAIL exh_pulses got=%0d exp=4", np); end
    checks++; if (exhausted_b !== 1'b1) begin errors++; $display("FAIL exh_flag got=%b exp=1", exhausted_b); end
    checks++; if (attempts_b !== 32'd4) begin errors++; $display("FAIL exh_attempts got=%0d exp=4", attempts_b); end
    checks++; if (selector_b !== 1'b0) begin errors++; $display("FAIL exh_selector got=%b exp=0", selector_b); end
    checks++; if (cyc !== 4 * (3 + lat)) begin errors++; $display("FAIL exh_cycles got=%0d exp=%0d", cyc, 4 * (3 + lat)); end
  endtask

  task automatic test_random_b();
    int cyc, hit_n, exp_att;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) hv[i] = 24'($urandom);
      target = (it == 0) ? 24'd0 : 24'($urandom_range(0, 24'h3FFFFF));
      lat = $urandom_range(0, 3);
      hit_n = -1;
      for (int n = 0; n < 4; n++) if (hit_n < 0 && hv[n] < target) hit_n = n;
      exp_att = (hit_n < 0) ? 4 : hit_n + 1;
      if (hit_n >= 0) last_nf_b = 32'(hit_n);
      go_b(); wait_b(cyc);
      checks++;
      if ({found_b, exhausted_b} !== {hit_n >= 0, hit_n < 0}) begin
        errors++; $display("FAIL rnd_b_outcome it=%0d got=%b exp=%b", it, {found_b, exhausted_b}, {hit_n >= 0, hit_n < 0});
      end
      checks++; if (attempts_b !== 32'(exp_att)) begin errors++; $display("FAIL rnd_b_attempts it=%0d got=%0d exp=%0d", it, attempts_b, exp_att); end
      checks++; if (nonce_found_b !== last_nf_b) begin errors++; $display("FAIL rnd_b_nonce it=%0d got=%0d exp=%0d", it, nonce_found_b, last_nf_b); end
      checks++; if (cyc !== exp_att * (3 + lat)) begin errors++; $display("FAIL rnd_b_cycles it=%0d got=%0d exp=%0d", it, cyc, exp_att * (3 + lat)); end
    end
  endtask

  task automatic test_random_a();
    int cyc, hit_n;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 15; i++) hv[i] = 24'($urandom);
      hv[15] = 24'd0;
      target = 24'($urandom_range(1, 24'h0FFFFF));
      lat = $urandom_range(0, 3);
      hit_n = -1;
      for (int n = 0; n < 16; n++) if (hit_n < 0 && hv[n] < target) hit_n = n;
      go_a(); wait_a(cyc);
      checks++; if (found_a !== 1'b1) begin errors++; $display("FAIL rnd_a_found it=%0d got=%b exp=1", it, found_a); end
      checks++; if (nonce_found_a !== 32'(hit_n)) begin errors++; $display("FAIL rnd_a_nonce it=%0d got=%0d exp=%0d", it, nonce_found_a, hit_n); end
      checks++; if (attempts_a !== 32'(hit_n + 1)) begin errors++; $display("FAIL rnd_a_attempts it=%0d got=%0d exp=%0d", it, attempts_a, hit_n + 1); end
      checks++; if (cyc !== (hit_n + 1) * (3 + lat)) begin errors++; $display("FAIL rnd_a_cycles it=%0d got=%0d exp=%0d", it, cyc, (hit_n + 1) * (3 + lat)); end
      last_nf_a = 32'(hit_n);
    end
  endtask

  task automatic test_spacing();
    int k, prev, np, spur_at;
    for (int i = 0; i < 16; i++) hv[i] = (i < 4) ? 24'($urandom_range(24'h100, 24'hFFFFFF)) : 24'($urandom_range(0, 24'hFF));
    target = 24'h000100; lat = 2;
    go_a();
    k = 0; prev = -1; np = 0; spur_at = -1;
    while (k < 300 && !found_a && !exhausted_a && !timeout_err_a) begin
      @(negedge clk); k++;
      spur = (k == spur_at);
      if (busy_a) begin
        checks++; if (selector_a !== 1'b1) begin errors++; $display("FAIL spacing_selector k=%0d got=%b exp=1", k, selector_a); end
      end
      if (hash_start_a) begin
        if (prev >= 0) begin
          checks++; if (k - prev !== 5) begin errors++; $display("FAIL spacing_gap got=%0d exp=5", k - prev); end
        end
        if (np == 0) spur_at = k + 4;
        np++; prev = k;
      end
    end
    spur = 0;
    checks++; if (np !== 5) begin errors++; $display("FAIL spacing_pulses got=%0d exp=5", np); end
    checks++; if (nonce_found_a !== 32'd4) begin errors++; $display("FAIL spacing_nonce got=%0d exp=4", nonce_found_a); end
    checks++; if (attempts_a !== 32'd5) begin errors++; $display("FAIL spacing_attempts got=%0d exp=5", attempts_a); end
    last_nf_a = 4;
  endtask

  task automatic test_timeout();
    int cyc, k;
    for (int i = 0; i < 16; i++) hv[i] = 24'hFFFFFF;
    target = 24'h000001; lat = 1; mute = 0;
    go_a();
    k = 0;
    while (k < 100 && nonce_a !== 32'd2) begin @(negedge clk); k++; end
    mute = 1;
    wait_a(cyc);
    checks++; if (timeout_err_a !== 1'b1) begin errors++; $display("FAIL tmo_flag got=%b exp=1", timeout_err_a); end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL tmo_cycles got=%0d exp=10", cyc); end
    checks++; if (attempts_a !== 32'd2) begin errors++; $display("FAIL tmo_attempts got=%0d exp=2", attempts_a); end
    checks++; if ({busy_a, selector_a} !== 2'b00) begin errors++; $display("FAIL tmo_idle got=%b exp=00", {busy_a, selector_a}); end
    mute = 0; lat = 7; hv[0] = 24'd0;
    go_a();
    checks++;
    if ({busy_a, nonce_a} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL tmo_restart got=%b/%h exp=1/00000000", busy_a, nonce_a);
    end
    wait_a(cyc);
    checks++;
    if ({found_a, timeout_err_a} !== 2'b10) begin
      errors++; $display("FAIL tmo_late_hit got=%b exp=10", {found_a, timeout_err_a});
    end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL tmo_late_cycles got=%0d exp=10", cyc); end
    last_nf_a = 0;
  endtask

  task automatic test_abort();
    int k;
    bit sent;
    for (int i = 0; i < 16; i++) hv[i] = 24'($urandom_range(24'h100, 24'hFFFFFF));
    hv[7] = 24'd0;
    target = 24'h000100; lat = 3; mute = 0;
    go_a();
    k = 0; sent = 0;
    while (k < 500 && !(nonce_a == 32'd7 && hash_start_a)) begin
      start_a = (nonce_a == 32'd3) && !sent;
      if (start_a) sent = 1;
      @(negedge clk); k++;
    end
    start_a = 0;
    @(negedge clk);
    abort = 1; start_a = 1;
    @(negedge clk);
    abort = 0; start_a = 0;
    checks++;
    if ({busy_a, selector_a, found_a, exhausted_a, timeout_err_a} !== 5'b0) begin
      errors++; $display("FAIL abort_idle got=%b exp=00000", {busy_a, selector_a, found_a, exhausted_a, timeout_err_a});
    end
    checks++; if (attempts_a !== 32'd7) begin errors++; $display("FAIL abort_attempts got=%0d exp=7", attempts_a); end
    checks++; if (nonce_found_a !== last_nf_a) begin errors++; $display("FAIL abort_nonce_found got=%0d exp=%0d", nonce_found_a, last_nf_a); end
    repeat (6) @(negedge clk);
    checks++;
    if ({busy_a, found_a, attempts_a} !== {2'b00, 32'd7}) begin
      errors++; $display("FAIL abort_late_valid got=%b/%0d exp=00/7", {busy_a, found_a}, attempts_a);
    end
  endtask

  task automatic test_async_reset();
    int k, cyc;
    for (int i = 0; i < 16; i++) hv[i] = 24'hFFFFFF;
    target = 24'h000100; lat = 3; mute = 0;
    go_a();
    k = 0;
    while (k < 500 && !(nonce_a == 32'd9 && hash_start_a)) begin @(negedge clk); k++; end
    @(negedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if ({selector_a, busy_a, hash_start_a, found_a, exhausted_a, timeout_err_a, nonce_a, nonce_found_a, attempts_a} !== 102'b0) begin
      errors++; $display("FAIL async_reset got=%b/%h/%h/%h exp=0", {selector_a, busy_a, hash_start_a}, nonce_a, nonce_found_a, attempts_a);
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    checks++; if ({busy_a, hash_start_a} !== 2'b00) begin errors++; $display("FAIL async_no_replay got=%b exp=00", {busy_a, hash_start_a}); end
    hv[0] = 24'd0;
    go_a();
    checks++; if ({busy_a, nonce_a} !== {1'b1, 32'd0}) begin errors++; $display("FAIL async_restart got=%b/%h exp=1/00000000", busy_a, nonce_a); end
    wait_a(cyc);
    checks++;
    if ({found_a, nonce_found_a, attempts_a} !== {1'b1, 32'd0, 32'd1}) begin
      errors++; $display("FAIL async_search got=%b/%0d/%0d exp=1/0/1", found_a, nonce_found_a, attempts_a);
    end
  endtask

  initial begin
    test_reset();
    test_found();
    test_exhaust();
    test_random_b();
    test_random_a();
    test_spacing();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
